// File: rtl/tr_or_pkg.sv
// Shared state encoding and index-width helper for the windowed OR accumulator.
package tr_or_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A window of one sample still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tr_or_tree.sv
// Switch-level OR reduction of a W-bit word, built only from pmos/nmos devices.
// Each tree node is a NOR2 plus an inverter; a lone leaf goes through an inverter pair.
module tr_or_tree #(
    parameter int W = 2
) (
    input  logic [W-1:0] d,
    output wire          y
);

    supply1 vdd;
    supply0 gnd;

    generate
        if (W == 1) begin : g_leaf
            // The buffer delays the lone leaf so that it stays in step with its paired sibling.
            wire yn;
            pmos p_in  (yn, vdd, d[0]);
            nmos n_in  (yn, gnd, d[0]);
            pmos p_out (y, vdd, yn);
            nmos n_out (y, gnd, yn);
        end else begin : g_node
            localparam int LO = (W == 2) ? 1 : (1 << ($clog2(W) - 1));
            localparam int HI = W - LO;
            wire a, b, mid, yn;

            if (W == 2) begin : g_pair
                assign a = d[0];
                assign b = d[1];
            end else begin : g_split
                tr_or_tree #(.W(LO)) u_lo (.d(d[LO-1:0]), .y(a));
                tr_or_tree #(.W(HI)) u_hi (.d(d[W-1:LO]), .y(b));
            end

            pmos p_a   (mid, vdd, a);
            pmos p_b   (yn, mid, b);
            nmos n_a   (yn, gnd, a);
            nmos n_b   (yn, gnd, b);
            pmos p_inv (y, vdd, yn);
            nmos n_inv (y, gnd, yn);
        end
    endgenerate

endmodule

// File: rtl/tr_or_accum.sv
// Multi-channel windowed OR accumulator with a valid/ready result handshake.
// Optional first-hit index per channel with TR_OR_FIRST_HIT_EN.
module tr_or_accum
    import tr_or_pkg::*;
#(
    parameter int W      = 4,
    parameter int CH     = 2,
    parameter int WINDOW = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic [CH*W-1:0]     D,
    input  logic                READY,
    output logic                BUSY,
    output logic                VALID,
    output logic [CH-1:0]       Y
`ifdef TR_OR_FIRST_HIT_EN
    ,
    output logic [CH*idx_width(WINDOW)-1:0] FIRST
`endif
);

    localparam int IW = idx_width(WINDOW);
    localparam logic [IW-1:0] LAST = IW'(WINDOW - 1);

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   cnt;
    logic [CH-1:0]   acc;
    wire  [CH-1:0]   hit;

    genvar c;
    generate
        for (c = 0; c < CH; c++) begin : g_ch
            tr_or_tree #(.W(W)) u_tree (
                .d (D[c*W +: W]),
                .y (hit[c])
            );
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (START)       state_next = ACCUM;
            ACCUM:   if (cnt == LAST) state_next = DONE;
            DONE:    if (READY)       state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // acc doubles as the result register: it is only cleared when a new window is accepted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc <= '0;
            cnt <= '0;
        end else if (state == IDLE && START) begin
            acc <= '0;
            cnt <= '0;
        end else if (state == ACCUM) begin
            acc <= acc | hit;
            cnt <= cnt + 1'b1;
        end
    end

`ifdef TR_OR_FIRST_HIT_EN
    logic [CH*IW-1:0] first_q;

    // A channel's first hit is the sample where it fires while its acc bit is still clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            first_q <= '0;
        end else if (state == IDLE && START) begin
            first_q <= '0;
        end else if (state == ACCUM) begin
            for (int i = 0; i < CH; i++) begin
                if (hit[i] && !acc[i]) first_q[i*IW +: IW] <= cnt;
            end
        end
    end

    assign FIRST = first_q;
`endif

    assign BUSY  = (state != IDLE);
    assign VALID = (state == DONE);
    assign Y     = acc;

endmodule

// File: tb/tb_tr_or_accum.sv
// Self-checking bench for tr_or_accum: a W=4/CH=2/WINDOW=8 instance plus a W=3/WINDOW=1 instance.
// Compile with TR_OR_FIRST_HIT_EN to also check the first-hit indices.
module tb_tr_or_accum;

    localparam int W   = 4;
    localparam int CH  = 2;
    localparam int WIN = 8;
    localparam int IW  = 3;

    logic       clk;
    logic       rst;
    logic       start;
    logic       ready;
    logic [7:0] d;
    logic       busy;
    logic       valid;
    logic [1:0] y;
    logic       start1;
    logic       ready1;
    logic [5:0] d1;
    logic       busy1;
    logic       valid1;
    logic [1:0] y1;
`ifdef TR_OR_FIRST_HIT_EN
    logic [5:0] first;
    logic [1:0] first1;
`endif

    int         n_cmp;
    int         n_fail;
    logic [7:0] samp [WIN];
    logic [1:0] exp_y;
    int         exp_first [CH];

    tr_or_accum #(.W(W), .CH(CH), .WINDOW(WIN)) dut (
        .CLK   (clk),
        .RST   (rst),
        .START (start),
        .D     (d),
        .READY (ready),
        .BUSY  (busy),
        .VALID (valid),
        .Y     (y)
`ifdef TR_OR_FIRST_HIT_EN
        ,
        .FIRST (first)
`endif
    );

    tr_or_accum #(.W(3), .CH(2), .WINDOW(1)) dut1 (
        .CLK   (clk),
        .RST   (rst),
        .START (start1),
        .D     (d1),
        .READY (ready1),
        .BUSY  (busy1),
        .VALID (valid1),
        .Y     (y1)
`ifdef TR_OR_FIRST_HIT_EN
        ,
        .FIRST (first1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a channel hits in a sample when any of its W bits is set; first hit is the earliest such sample.
    task automatic build_model();
        exp_y = '0;
        for (int c = 0; c < CH; c++) begin
            exp_first[c] = 0;
            for (int i = 0; i < WIN; i++) begin
                if (((samp[i] >> (c * W)) & 8'h0F) != 0 && !exp_y[c]) begin
                    exp_y[c]     = 1'b1;
                    exp_first[c] = i;
                end
            end
        end
    endtask

    task automatic check_first(input string tag);
`ifdef TR_OR_FIRST_HIT_EN
        for (int c = 0; c < CH; c++) checkOutput(tag, 32'(first[c*IW +: IW]), exp_first[c]);
`else
        if (tag.len() == 0) $display("[TB] empty tag");
`endif
    endtask

    task automatic applyStimulus(input bit noise);
        build_model();
        start = 1'b1;
        d     = 8'($urandom);
        tick();
        checkOutput("busy_after_start", busy, 1);
        checkOutput("valid_after_start", valid, 0);
        checkOutput("y_cleared_on_start", y, 0);
        for (int i = 0; i < WIN; i++) begin
            d     = samp[i];
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            ready = 1'($urandom_range(0, 1));
            tick();
            if (i < WIN - 1) begin
                checkOutput("valid_early", valid, 0);
                checkOutput("busy_accum", busy, 1);
            end
        end
        start = 1'b0;
        checkOutput("valid_at_window_end", valid, 1);
        checkOutput("busy_in_done", busy, 1);
        checkOutput("y_result", y, exp_y);
        check_first("first_result");
    endtask

    task automatic handshake(input int stall);
        ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            start = 1'($urandom_range(0, 1));
            tick();
            checkOutput("valid_stall", valid, 1);
            checkOutput("y_stall", y, exp_y);
        end
        ready = 1'b1;
        start = 1'b1;
        tick();
        checkOutput("valid_after_hs", valid, 0);
        checkOutput("busy_after_hs", busy, 0);
        checkOutput("y_kept_idle", y, exp_y);
        ready = 1'b0;
        start = 1'b0;
        tick();
        checkOutput("idle_after_hs", busy, 0);
        checkOutput("y_kept_idle2", y, exp_y);
    endtask

    initial begin
        logic [1:0] e1;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        ready  = 1'b0;
        d      = '0;
        start1 = 1'b0;
        ready1 = 1'b0;
        d1     = '0;
        repeat (3) tick();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_valid", valid, 0);
        checkOutput("reset_y", y, 0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            tick();
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_valid", valid, 0);
            checkOutput("idle_y", y, 0);
        end

        for (int i = 0; i < WIN; i++) samp[i] = 8'h00;
        samp[2] = 8'h20;
        applyStimulus(1'b0);
        checkOutput("directed_y", y, 2'b10);
`ifdef TR_OR_FIRST_HIT_EN
        checkOutput("directed_first_ch1", 32'(first[5:3]), 2);
        checkOutput("directed_first_ch0", 32'(first[2:0]), 0);
`endif
        handshake(5);

        for (int i = 0; i < WIN; i++) samp[i] = 8'($urandom);
        applyStimulus(1'b1);
        handshake($urandom_range(0, 3));

        for (int w = 0; w < 5; w++) begin
            for (int i = 0; i < WIN; i++)
                samp[i] = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            applyStimulus(1'b1);
            handshake($urandom_range(0, 3));
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        d     = 8'hFF;
        repeat (3) tick();
        checkOutput("pre_reset_y", y, 2'b11);
        rst = 1'b1;
        tick();
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_valid", valid, 0);
        checkOutput("midreset_y", y, 0);
`ifdef TR_OR_FIRST_HIT_EN
        checkOutput("midreset_first", 32'(first), 0);
`endif
        rst = 1'b0;
        d   = '0;
        tick();
        checkOutput("post_reset_idle", busy, 0);

        for (int i = 0; i < WIN; i++) samp[i] = 8'($urandom) & 8'h11;
        applyStimulus(1'b0);
        handshake(1);

        for (int p = 0; p < 8; p++) begin
            d1     = {3'(7 - p), 3'(p)};
            e1[0]  = (p != 0);
            e1[1]  = (p != 7);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            checkOutput("w1_busy", busy1, 1);
            checkOutput("w1_valid_early", valid1, 0);
            tick();
            checkOutput("w1_valid", valid1, 1);
            checkOutput("w1_y", y1, e1);
`ifdef TR_OR_FIRST_HIT_EN
            checkOutput("w1_first", 32'(first1), 0);
`endif
            ready1 = 1'b1;
            tick();
            checkOutput("w1_valid_after_hs", valid1, 0);
            ready1 = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
